reg_alu_seq: RTL

REG_ALU_SEQ -- requirements
Module: reg_alu_seq

---
 rtl/reg_alu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_seq
// Brief    : Instruction queue + issue sequencer driving a register-file/ALU.
// Revision : 1.0 - initial release
// ============================================================================
module reg_alu_seq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sel,
  output logic        wr,
  output logic [1:0]  op,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic [7:0]  d_in,
  input  logic        cout,
  output logic        rd_valid,
  output logic        carry,
  output logic        busy
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = (c_AW)'(1);

  localparam logic [1:0] c_CLS_NOP  = 2'b00;
  localparam logic [1:0] c_CLS_LDI  = 2'b01;
  localparam logic [1:0] c_CLS_ALU  = 2'b10;
  localparam logic [1:0] c_CLS_READ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CWAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_count;
  logic [15:0]      r_issue;
  logic             r_carry;
  logic             w_push;
  logic             w_pop;
  logic             w_q_nonempty;
  logic             w_issue_alu;
  logic             w_unused;

  // Readiness comes from the registered count only, so a push while full is
  // dropped even if the FSM pops in the same cycle.
  assign in_ready     = (r_count != c_FULL);
  assign w_push       = in_valid && in_ready;
  assign w_q_nonempty = (r_count != '0);
  assign w_issue_alu  = (r_issue[15:14] == c_CLS_ALU);
  assign busy         = w_q_nonempty || (r_state != S_IDLE);
  assign carry        = r_carry;
  assign w_unused     = ^r_issue[2:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_issue <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + c_PTR_ONE;
        r_issue <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (r_state == S_CWAIT) begin
        r_carry <= cout;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_q_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An ALU word holds off the next pop for one cycle so cout can settle.
        if (w_issue_alu) begin
          w_state_nxt = S_CWAIT;
        end else if (w_q_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CWAIT: begin
        if (w_q_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel       = 1'b0;
    wr        = 1'b0;
    op        = 2'b00;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_addr   = 3'd0;
    d_in      = 8'd0;
    rd_valid  = 1'b0;
    if (r_state == S_ISSUE) begin
      case (r_issue[15:14])
        c_CLS_LDI: begin
          wr      = 1'b1;
          wr_addr = r_issue[13:11];
          d_in    = r_issue[7:0];
        end
        c_CLS_ALU: begin
          wr        = 1'b1;
          sel       = 1'b1;
          op        = r_issue[13:12];
          rd_addr_a = r_issue[11:9];
          rd_addr_b = r_issue[8:6];
          wr_addr   = r_issue[5:3];
        end
        c_CLS_READ: begin
          rd_valid  = 1'b1;
          rd_addr_a = r_issue[11:9];
          rd_addr_b = r_issue[8:6];
        end
        c_CLS_NOP: begin
          wr = 1'b0;
        end
        default: wr = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
